// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus receiver: instruction classes, display
// geometry and the DDRAM address-counter wrap rules.
package lcd_pkg;

    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam int         NCELLS     = 32;

    localparam logic [7:0] OPC_SET_ADDR = 8'h80;
    localparam logic [7:0] OPC_CGRAM    = 8'h40;
    localparam logic [7:0] OPC_FUNC     = 8'h20;
    localparam logic [7:0] OPC_SHIFT    = 8'h10;
    localparam logic [7:0] OPC_DISP     = 8'h08;
    localparam logic [7:0] OPC_ENTRY    = 8'h04;
    localparam logic [7:0] OPC_HOME     = 8'h02;
    localparam logic [7:0] OPC_CLEAR    = 8'h01;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_SET_ADDR,
        OP_DISP_CTRL,
        OP_ENTRY,
        OP_HOME,
        OP_CLEAR
    } op_e;

    // Highest set bit selects the class; CGRAM, function set and shift are no-ops here.
    function automatic op_e op_decode(input logic [7:0] d);
        if      (|(d & OPC_SET_ADDR)) return OP_SET_ADDR;
        else if (|(d & (OPC_CGRAM | OPC_FUNC | OPC_SHIFT))) return OP_NONE;
        else if (|(d & OPC_DISP))     return OP_DISP_CTRL;
        else if (|(d & OPC_ENTRY))    return OP_ENTRY;
        else if (|(d & OPC_HOME))     return OP_HOME;
        else if (|(d & OPC_CLEAR))    return OP_CLEAR;
        else                          return OP_NONE;
    endfunction

    function automatic logic in_window(input logic [6:0] a);
        return (a[5:4] == 2'b00);
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h0F)                  return LINE1_BASE;
            else if (a == LINE1_BASE + 7'hF) return 7'h00;
            else                             return a + 7'd1;
        end else begin
            if (a == LINE1_BASE)             return 7'h0F;
            else if (a == 7'h00)             return LINE1_BASE + 7'hF;
            else                             return a - 7'd1;
        end
    endfunction

endpackage

// File: rtl/lcd_bus_receiver_edge_sync.sv
// Bus input staging and E falling-edge detection. Defining LCD_RX_SYNC_EN adds
// a two-flop synchronizer on all bus inputs for asynchronous pins.
module lcd_edge_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    output logic       xfer_valid,
    output logic       xfer_rs,
    output logic       xfer_rw,
    output logic [7:0] xfer_data
);

    logic [10:0] bus_s;

`ifdef LCD_RX_SYNC_EN
    logic [10:0] meta_q, meta_d;
    logic [10:0] sync_q, sync_d;

    always_comb begin
        meta_d = {lcd_e, lcd_rs, lcd_rw, lcd_data};
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign bus_s = sync_q;
`else
    assign bus_s = {lcd_e, lcd_rs, lcd_rw, lcd_data};
`endif

    logic       e_q, e_d;
    logic       valid_q, valid_d;
    logic [9:0] hold_q, hold_d;

    // hold_q keeps rs/rw/data from the last cycle E was seen high.
    always_comb begin
        e_d     = bus_s[10];
        valid_d = e_q & ~bus_s[10];
        hold_d  = bus_s[10] ? bus_s[9:0] : hold_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_q     <= 1'b0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            e_q     <= e_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

    assign xfer_valid = valid_q;
    assign xfer_rs    = hold_q[9];
    assign xfer_rw    = hold_q[8];
    assign xfer_data  = hold_q[7:0];

endmodule

// File: rtl/lcd_bus_receiver.sv
// HD44780-style write-bus receiver with a 2x16 character mirror and registered
// read port. Build option: LCD_RX_SYNC_EN (input synchronizers, see lcd_edge_sync).
module lcd_bus_receiver
    import lcd_pkg::*;
#(
    parameter int         BUSY_CYCLES = 40,
    parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] cur_addr,
    output logic       display_on,
    output logic       busy,
    output logic       wr_strobe,
    output logic       cmd_strobe,
    output logic       err
);

    localparam int CW = $clog2(BUSY_CYCLES + 1);

    logic       xfer_valid, xfer_rs, xfer_rw;
    logic [7:0] xfer_data;

    lcd_edge_sync u_edge (
        .clk        (clk),
        .rst        (rst),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .xfer_valid (xfer_valid),
        .xfer_rs    (xfer_rs),
        .xfer_rw    (xfer_rw),
        .xfer_data  (xfer_data)
    );

    logic [7:0]    mem [NCELLS];
    logic          mem_we;
    logic [4:0]    mem_waddr;
    logic [7:0]    mem_wdata;

    logic [6:0]    cur_addr_q, cur_addr_d;
    logic          display_on_q, display_on_d;
    logic          dir_inc_q, dir_inc_d;
    logic          busy_q, busy_d;
    logic          wr_strobe_q, wr_strobe_d;
    logic          cmd_strobe_q, cmd_strobe_d;
    logic          err_q, err_d;
    logic          sweep_q, sweep_d;
    logic [4:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    rd_char_q, rd_char_d;

    always_comb begin
        cur_addr_d   = cur_addr_q;
        display_on_d = display_on_q;
        dir_inc_d    = dir_inc_q;
        wr_strobe_d  = 1'b0;
        cmd_strobe_d = 1'b0;
        err_d        = 1'b0;
        sweep_d      = sweep_q;
        idx_d        = idx_q;
        cnt_d        = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        mem_we       = 1'b0;
        mem_waddr    = idx_q;
        mem_wdata    = BLANK_CHAR;
        rd_char_d    = mem[rd_addr];

        if (sweep_q) begin
            mem_we = 1'b1;
            if (idx_q == 5'(NCELLS - 1)) sweep_d = 1'b0;
            else                         idx_d   = idx_q + 5'd1;
        end

        // sweep_q is included so a transfer cannot land in the first post-reset cycle.
        if (xfer_valid) begin
            if (xfer_rw || busy_q || sweep_q) begin
                err_d = 1'b1;
            end else if (xfer_rs) begin
                if (in_window(cur_addr_q)) begin
                    mem_we    = 1'b1;
                    mem_waddr = {cur_addr_q[6], cur_addr_q[3:0]};
                    mem_wdata = xfer_data;
                end
                cur_addr_d  = addr_step(cur_addr_q, dir_inc_q);
                wr_strobe_d = 1'b1;
            end else begin
                cmd_strobe_d = 1'b1;
                case (op_decode(xfer_data))
                    OP_SET_ADDR:  cur_addr_d   = xfer_data[6:0];
                    OP_DISP_CTRL: display_on_d = xfer_data[2];
                    OP_ENTRY:     dir_inc_d    = xfer_data[1];
                    OP_HOME:      cur_addr_d   = 7'h00;
                    OP_CLEAR: begin
                        cur_addr_d = 7'h00;
                        dir_inc_d  = 1'b1;
                        sweep_d    = 1'b1;
                        idx_d      = 5'd0;
                        cnt_d      = CW'(BUSY_CYCLES);
                    end
                    default: ;
                endcase
            end
        end

        busy_d = sweep_d | (cnt_d != '0);
    end

    // Reset leaves sweep_q set so the mirror is blanked right after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_addr_q   <= 7'h00;
            display_on_q <= 1'b0;
            dir_inc_q    <= 1'b1;
            busy_q       <= 1'b0;
            wr_strobe_q  <= 1'b0;
            cmd_strobe_q <= 1'b0;
            err_q        <= 1'b0;
            sweep_q      <= 1'b1;
            idx_q        <= 5'd0;
            cnt_q        <= '0;
            rd_char_q    <= 8'h00;
        end else begin
            cur_addr_q   <= cur_addr_d;
            display_on_q <= display_on_d;
            dir_inc_q    <= dir_inc_d;
            busy_q       <= busy_d;
            wr_strobe_q  <= wr_strobe_d;
            cmd_strobe_q <= cmd_strobe_d;
            err_q        <= err_d;
            sweep_q      <= sweep_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            rd_char_q    <= rd_char_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign rd_char    = rd_char_q;
    assign cur_addr   = cur_addr_q;
    assign display_on = display_on_q;
    assign busy       = busy_q;
    assign wr_strobe  = wr_strobe_q;
    assign cmd_strobe = cmd_strobe_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Self-checking bench for lcd_bus_receiver: strobe scoreboard plus per-scenario
// checks of the character mirror, address counter and busy timing.
module tb_lcd_bus_receiver;

    localparam logic [2:0] EV_WR  = 3'b100;
    localparam logic [2:0] EV_CMD = 3'b010;
    localparam logic [2:0] EV_ERR = 3'b001;
    localparam logic [7:0] BL     = 8'h20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       lcd_e = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data = 8'h00;
    logic [4:0] rd_addr = 5'd0;
    logic [7:0] rd_char;
    logic [6:0] cur_addr;
    logic       display_on, busy, wr_strobe, cmd_strobe, err;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];
    logic [7:0] model[32];

    lcd_bus_receiver #(.BUSY_CYCLES(40), .BLANK_CHAR(8'h20)) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd_e      (lcd_e),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_data   (lcd_data),
        .rd_addr    (rd_addr),
        .rd_char    (rd_char),
        .cur_addr   (cur_addr),
        .display_on (display_on),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .cmd_strobe (cmd_strobe),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Strobe monitor: every pulse must match the next expected event.
    always @(negedge clk) begin
        if (rst && (wr_strobe || cmd_strobe || err)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: got {wr,cmd,err}=%b, none expected", {wr_strobe, cmd_strobe, err});
            end else begin
                logic [2:0] exp;
                exp = sb.pop_front();
                if ({wr_strobe, cmd_strobe, err} !== exp) begin
                    errors++;
                    $display("FAIL strobe_kind: got {wr,cmd,err}=%b, expected %b", {wr_strobe, cmd_strobe, err}, exp);
                end
            end
        end
    end

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input logic [2:0] exp);
        sb.push_back(exp);
        @(posedge clk); #1;
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
        @(posedge clk); #1;
        lcd_e = 1'b0;
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic read_cell(input logic [4:0] a, output logic [7:0] v);
        rd_addr = a;
        @(posedge clk); #1;
        v = rd_char;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 20 && !busy; i++) begin
            @(posedge clk); #1;
        end
        while (busy && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int n;
        logic [7:0] v;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({cur_addr, display_on, busy, wr_strobe, cmd_strobe, err, rd_char} !== {7'h00, 5'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h don=%b busy=%b str=%b%b%b rd=%h, expected all zero",
                     cur_addr, display_on, busy, wr_strobe, cmd_strobe, err, rd_char);
        end
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL reset_sweep_len: busy fell after %0d cycles, expected 32", n);
        end
        for (int i = 0; i < 32; i++) model[i] = BL;
        read_cell(5'h1F, v);
        checks++;
        if (v !== 8'h20) begin
            errors++;
            $display("FAIL reset_cell31: got %h, expected 20", v);
        end
        checks++;
        if (cur_addr !== 7'h00 || display_on !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got addr=%h don=%b, expected 00 0", cur_addr, display_on);
        end
    endtask

    task automatic test_write_line0();
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'h80, EV_CMD);
        xfer(1'b1, 1'b0, 8'h48, EV_WR);
        xfer(1'b1, 1'b0, 8'h49, EV_WR);
        settle();
        model[0] = 8'h48; model[1] = 8'h49;
        for (int i = 0; i < 2; i++) begin
            read_cell(5'(i), v);
            checks++;
            if (v !== model[i]) begin
                errors++;
                $display("FAIL line0_cell%0d: got %h, expected %h", i, v, model[i]);
            end
        end
        checks++;
        if (cur_addr !== 7'h02) begin
            errors++;
            $display("FAIL line0_addr: got %h, expected 02", cur_addr);
        end
    endtask

    task automatic test_line_wrap();
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'h8F, EV_CMD);
        xfer(1'b1, 1'b0, 8'h41, EV_WR);
        xfer(1'b1, 1'b0, 8'h42, EV_WR);
        settle();
        model[15] = 8'h41; model[16] = 8'h42;
        read_cell(5'd15, v);
        checks++;
        if (v !== 8'h41) begin errors++; $display("FAIL wrap_cell15: got %h, expected 41", v); end
        read_cell(5'd16, v);
        checks++;
        if (v !== 8'h42) begin errors++; $display("FAIL wrap_cell16: got %h, expected 42", v); end
        checks++;
        if (cur_addr !== 7'h41) begin errors++; $display("FAIL wrap_addr: got %h, expected 41", cur_addr); end
    endtask

    task automatic test_decrement();
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'h04, EV_CMD);
        xfer(1'b0, 1'b0, 8'h80, EV_CMD);
        xfer(1'b1, 1'b0, 8'h5A, EV_WR);
        settle();
        model[0] = 8'h5A;
        checks++;
        if (cur_addr !== 7'h4F) begin errors++; $display("FAIL dec_wrap_addr: got %h, expected 4f", cur_addr); end
        xfer(1'b0, 1'b0, 8'h90, EV_CMD);
        xfer(1'b1, 1'b0, 8'h31, EV_WR);
        settle();
        checks++;
        if (cur_addr !== 7'h0F) begin errors++; $display("FAIL dec_outside_addr: got %h, expected 0f", cur_addr); end
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            checks++;
            if (v !== model[i]) begin
                errors++;
                $display("FAIL dec_cell%0d: got %h, expected %h", i, v, model[i]);
            end
        end
    endtask

    task automatic test_clear();
        int n;
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'h01, EV_CMD);
        fork
            count_busy(n);
            begin
                repeat (10) @(posedge clk);
                xfer(1'b1, 1'b0, 8'h33, EV_ERR);
            end
        join
        checks++;
        if (n !== 40) begin errors++; $display("FAIL clear_busy_len: busy high %0d cycles, expected 40", n); end
        for (int i = 0; i < 32; i++) model[i] = BL;
        for (int i = 0; i < 32; i++) begin
            read_cell(5'(i), v);
            checks++;
            if (v !== BL) begin
                errors++;
                $display("FAIL clear_cell%0d: got %h, expected 20", i, v);
            end
        end
        xfer(1'b1, 1'b0, 8'h33, EV_WR);
        settle();
        model[0] = 8'h33;
        read_cell(5'd0, v);
        checks++;
        if (v !== 8'h33) begin errors++; $display("FAIL clear_then_write: got %h, expected 33", v); end
        checks++;
        if (cur_addr !== 7'h01) begin errors++; $display("FAIL clear_dir_inc: got %h, expected 01", cur_addr); end
    endtask

    task automatic test_rw_err();
        logic [7:0] v;
        xfer(1'b1, 1'b1, 8'h55, EV_ERR);
        settle();
        checks++;
        if (cur_addr !== 7'h01) begin errors++; $display("FAIL rw_addr: got %h, expected 01", cur_addr); end
        read_cell(5'd1, v);
        checks++;
        if (v !== BL) begin errors++; $display("FAIL rw_cell1: got %h, expected 20", v); end
    endtask

    task automatic test_display_home();
        xfer(1'b0, 1'b0, 8'h0C, EV_CMD);
        settle();
        checks++;
        if (display_on !== 1'b1) begin errors++; $display("FAIL disp_on: got %b, expected 1", display_on); end
        xfer(1'b0, 1'b0, 8'h02, EV_CMD);
        xfer(1'b0, 1'b0, 8'h20, EV_CMD);
        settle();
        checks++;
        if (cur_addr !== 7'h00 || display_on !== 1'b1) begin
            errors++;
            $display("FAIL home: got addr=%h don=%b, expected 00 1", cur_addr, display_on);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'hC0, EV_CMD);
        xfer(1'b1, 1'b0, 8'h57, EV_WR);
        xfer(1'b1, 1'b0, 8'h58, EV_WR);
        xfer(1'b1, 1'b0, 8'h59, EV_WR);
        settle();
        model[16] = 8'h57; model[17] = 8'h58; model[18] = 8'h59;
        for (int i = 16; i < 19; i++) begin
            read_cell(5'(i), v);
            checks++;
            if (v !== model[i]) begin
                errors++;
                $display("FAIL b2b_cell%0d: got %h, expected %h", i, v, model[i]);
            end
        end
        checks++;
        if (cur_addr !== 7'h43) begin errors++; $display("FAIL b2b_addr: got %h, expected 43", cur_addr); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        logic [7:0] v;
        xfer(1'b0, 1'b0, 8'h01, EV_CMD);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        sb.delete();
        #2;
        checks++;
        if ({cur_addr, display_on, busy, wr_strobe, cmd_strobe, err, rd_char} !== {7'h00, 5'b0, 8'h00}) begin
            errors++;
            $display("FAIL midreset_outputs: got addr=%h don=%b busy=%b str=%b%b%b rd=%h, expected all zero",
                     cur_addr, display_on, busy, wr_strobe, cmd_strobe, err, rd_char);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
        checks++;
        if (n !== 32) begin errors++; $display("FAIL midreset_sweep_len: %0d cycles, expected 32", n); end
        read_cell(5'd0, v);
        checks++;
        if (v !== BL) begin errors++; $display("FAIL midreset_cell0: got %h, expected 20", v); end
    endtask

    task automatic check_drained(input string tag);
        repeat (4) @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: %0d expected strobes missing, expected 0", tag, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_write_line0();     check_drained("line0");
        test_line_wrap();       check_drained("wrap");
        test_decrement();       check_drained("dec");
        test_clear();           check_drained("clear");
        test_rw_err();          check_drained("rw");
        test_display_home();    check_drained("disp");
        test_back_to_back();    check_drained("b2b");
        test_reset_mid_sweep(); check_drained("midreset");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
# lcd_bus_receiver

Receiving end of the character-LCD write bus driven by `calculator` (`lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_data`). It decodes HD44780-style instruction and data writes, tracks the DDRAM address counter, and keeps a 2x16 character mirror of the display. The mirror is readable through a registered read port. The block serves as a synthesizable display mirror for on-board debug (`seg`/`led` readback) and as the bus checker in calculator benches.

## Interface
Parameters:
- `BUSY_CYCLES`, 40: cycles `busy` stays high after a clear instruction; must be ≥ 32.
- `BLANK_CHAR`, 8'h20: fill value for reset and clear.

Ports:
- `clk` input 1: sole clock; all logic rises on `posedge clk`.
- `rst` input 1: asynchronous, active-low reset.
- `lcd_e` input 1: bus enable; a transfer completes on its falling edge.
- `lcd_rs` input 1: 0 = instruction, 1 = data.
- `lcd_rw` input 1: 0 = write, 1 = read (unsupported).
- `lcd_data` input 8: bus data.
- `rd_addr` input 5: mirror cell index; bit 4 = line, bits 3:0 = column.
- `rd_char` output 8: cell contents, one cycle after `rd_addr`.
- `cur_addr` output 7: DDRAM address counter.
- `display_on` output 1: D bit of the last display-control instruction.
- `busy` output 1: clear sweep or busy hold in progress.
- `wr_strobe` output 1: one-cycle pulse per accepted data write.
- `cmd_strobe` output 1: one-cycle pulse per accepted instruction.
- `err` output 1: one-cycle pulse on a rejected transfer (read cycle, or any transfer while busy).

## Operation
- Reset (`rst`=0, asynchronous):
  - `cur_addr`=0, `display_on`=0, entry direction = increment.
  - `busy`=0, all strobes 0, `rd_char`=0.
  - All 32 cells = `BLANK_CHAR`, realized as a forced 32-cycle sweep after `rst` deasserts. `busy`=1 during the sweep. No reset-time parallel clear.
- A transfer is accepted on a detected `lcd_e` falling edge. `rs`, `rw` and `data` are the values sampled in the same cycle E was last high.
- `rw`=1 → `err` pulse; no state change.
- `busy`=1 → `err` pulse; no state change.
- Instruction decode uses priority on the highest set bit of `data`:
  - 1xxxxxxx, set address: `cur_addr`=`data[6:0]`.
  - 001xxxxx, function set: accepted, no effect.
  - 00001DCB, display control: `display_on`=D.
  - 000001IS, entry mode: direction = I (1 = increment); S ignored.
  - 0000001x, home: `cur_addr`=0.
  - 00000001, clear: `cur_addr`=0, direction = increment, sweep starts.
  - 00000000: accepted, no effect.
  - Every accepted instruction pulses `cmd_strobe`.
- Data write:
  - The visible window is `cur_addr` 0x00–0x0F (line 0) and 0x40–0x4F (line 1).
  - If `cur_addr` is in the window, the cell at {`cur_addr[6]`, `cur_addr[3:0]`} is written. Outside the window the write is dropped.
  - `cur_addr` then steps and `wr_strobe` pulses in both cases.
- Address step:
  - ±1 modulo 128, except increment 0x0F→0x40, increment 0x4F→0x00, decrement 0x40→0x0F, decrement 0x00→0x4F.
- Clear sweep:
  - Writes one cell per cycle, index 0..31.
  - `busy` stays high for `BUSY_CYCLES` cycles from the accepting edge.
  - `rd_char` returns in-progress values during the sweep.

## Timing
- E falling edge is detected in the first cycle E samples low. State updates and strobes are registered on the next edge, so effects are visible 2 cycles after the sample (4 with `LCD_RX_SYNC_EN`).
- `rd_char` latency is 1 cycle. When a read and a write hit the same cell in the same cycle, `rd_char` returns the old value.
- Minimum E high/low time is 1 sampled cycle. Pulses shorter than 1 cycle are undefined.
- Reset mid-sweep or mid-transfer: everything returns to reset values and the sweep restarts from cell 0.

## Configuration
- `LCD_RX_SYNC_EN` defined: all four bus inputs pass through two-flop synchronizers before edge detection, adding 2 cycles of latency. Safe for asynchronous pins.
- Undefined: inputs are registered once, for edge detection only. Bus must be synchronous to `clk`.

## Structure
- Package `lcd_pkg`:
  - opcode-class masks, `LINE1_BASE`=7'h40, `NCELLS`=32;
  - `addr_step` function implementing the wrap rules.
- Sub-module `lcd_edge_sync`: optional synchronizer plus E falling-edge detector; emits `xfer_valid` with `rs`/`rw`/`data` captured in the same cycle.

## Test plan
- Release reset, wait 32 cycles → `busy` falls after 32 cycles, `rd_addr`=5'h1F reads 8'h20, `cur_addr`=0, `display_on`=0.
- Instruction 0x80, then data 0x48, 0x49 → cells 0 and 1 = 'H','I', `cur_addr`=0x02, two `wr_strobe` pulses.
- Instruction 0x8F, then data 0x41, 0x42 → cell 15 = 'A', cell 16 = 'B', `cur_addr`=0x41.
- Instruction 0x04 then 0x80, data 0x5A → cell 0 = 'Z', `cur_addr`=0x4F. Instruction 0x90, data 0x31 → no cell changes, `cur_addr`=0x0F.
- Instruction 0x01, then data 0x33 ten cycles later → `err` pulse, all cells blank, `busy` high for 40 cycles. Data 0x33 after `busy` falls → cell 0 = '3'.
- `lcd_rw`=1 transfer → `err` pulse only. Instruction 0x0C → `display_on`=1, `cmd_strobe` pulse. Assert `rst` mid-sweep → outputs return to reset values.
